// File: rtl/filt_scratch_reader_pkg.sv
// Shared definitions for the filter scratchpad reader: FSM encoding and
// the latency/depth constants that size the read-issue throttle.
package filt_scratch_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Scratchpad returns data this many cycles after the read enable.
  localparam int RD_LATENCY = 1;

  // Entries in the output skid buffer.
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/filt_scratch_reader_skid_buf.sv
// Two-entry valid/ready buffer carrying a scratchpad word plus its two
// boundary markers. Empty buffer falls through so a returning read can be
// presented on the same cycle it arrives. The upstream guarantees it never
// pushes into a full buffer that is not popping.
module filt_rd_skid_buf
  import filt_scratch_reader_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last_elem,
  input  logic              in_last_filt,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last_elem,
  output logic              out_last_filt,
  output logic [1:0]        occupancy
);

  localparam int PAY_W = DATA_W + 2;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] slot0;
  logic [PAY_W-1:0] slot1;
  logic [PAY_W-1:0] out_pay;
  logic [1:0]       count;
  logic             pop;
  logic             empty;
  logic             full;

  assign in_pay    = {in_last_filt, in_last_elem, in_data};
  assign empty     = (count == 2'd0);
  assign full      = (count == 2'(SKID_DEPTH));
  assign out_valid = !empty || in_valid;
  assign out_pay   = empty ? in_pay : slot0;
  assign pop       = out_valid && out_ready;
  assign {out_last_filt, out_last_elem, out_data} = out_pay;
  assign occupancy = count;

  // Occupancy bookkeeping: push when a beat arrives that is not leaving at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= 2'd0;
    end else if (empty) begin
      if (in_valid && !out_ready) count <= 2'd1;
    end else if (!full) begin
      if (in_valid && !pop)      count <= 2'd2;
      else if (!in_valid && pop) count <= 2'd0;
    end else begin
      if (pop && !in_valid)      count <= 2'd1;
    end
  end

  // Payload slots; slot0 is always the head presented downstream.
  always_ff @(posedge clk) begin
    if (empty) begin
      if (in_valid && !out_ready) slot0 <= in_pay;
    end else if (!full) begin
      if (in_valid && pop)        slot0 <= in_pay;
      else if (in_valid)          slot1 <= in_pay;
    end else begin
      if (pop) begin
        slot0 <= slot1;
        if (in_valid) slot1 <= in_pay;
      end
    end
  end

endmodule

// File: rtl/filt_scratch_reader.sv
// Replays filters resident in the scratchpad to the MAC stage: each filter
// is streamed win_count times, element by element, with boundary markers.
// Reads are throttled so in-flight reads plus buffered beats never exceed
// the skid buffer, giving full throughput without loss under backpressure.
module filt_scratch_reader
  import filt_scratch_reader_pkg::*;
#(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int SCRATCH_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_LEN-1:0]      filt_len,
  input  logic [ADDR_LEN-1:0]      filt_count,
  input  logic [ADDR_LEN-1:0]      win_count,
  output logic [ADDR_LEN-1:0]      filt_raddr,
  output logic                     filt_scratch_ren,
  input  logic [SCRATCH_WIDTH-1:0] filt_rdata,
  output logic [SCRATCH_WIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last_elem,
  output logic                     out_last_filt,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int SUM_W = ADDR_LEN + 3;

  state_t state;
  state_t state_nxt;

  logic [ADDR_LEN-1:0] len_q;
  logic [ADDR_LEN-1:0] cnt_q;
  logic [ADDR_LEN-1:0] win_q;
  logic [ADDR_LEN-1:0] e_q;
  logic [ADDR_LEN-1:0] w_q;
  logic [ADDR_LEN-1:0] f_q;
  logic [ADDR_LEN:0]   base_q;
  logic                err_q;

  logic [SUM_W-1:0] end_cur;
  logic [SUM_W-1:0] end_nxt;
  logic             ovf_now;
  logic             ovf_next;
  logic             elem_end;
  logic             win_end;
  logic             filt_end;
  logic             last_filt_p0;
  logic             err_set;
  logic             accept;
  logic             zero_cfg;
  logic             space;
  logic             ren;
  logic             drained;

  logic                     vld_p1;
  logic                     last_elem_p1;
  logic                     last_filt_p1;
  logic [1:0]               occ;
  logic                     sk_valid;
  logic [SCRATCH_WIDTH-1:0] sk_data;
  logic                     sk_last_elem;
  logic                     sk_last_filt;
  logic                     pop;
  logic [2:0]               entries;

  // Window of the current filter and of the one after it, for overflow tests.
  assign end_cur  = SUM_W'(base_q) + SUM_W'(len_q);
  assign end_nxt  = end_cur + SUM_W'(len_q);
  assign ovf_now  = end_cur > SUM_W'(SCRATCH_DEPTH);
  assign ovf_next = end_nxt > SUM_W'(SCRATCH_DEPTH);

  assign elem_end = (e_q == len_q - ADDR_LEN'(1));
  assign win_end  = (w_q == win_q - ADDR_LEN'(1));
  assign filt_end = (f_q == cnt_q - ADDR_LEN'(1));

  // A beat ends the run if it closes the last filter, or closes a filter
  // whose successor would not fit in the scratchpad.
  assign last_filt_p0 = elem_end && win_end && (filt_end || ovf_next);
  assign err_set      = ((state == ST_RUN) && ovf_now) ||
                        (ren && elem_end && win_end && !filt_end && ovf_next);

  assign accept   = (state == ST_IDLE) && start;
  assign zero_cfg = (filt_len == '0) || (filt_count == '0) || (win_count == '0);

  assign entries = {1'b0, occ} + {2'b0, vld_p1};
  assign space   = entries < 3'(SKID_DEPTH);
  assign pop     = sk_valid && out_ready;
  assign drained = (entries == {2'b0, pop});

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = zero_cfg ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        ren  = !ovf_now && space;
        if (ovf_now || (ren && last_filt_p0)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drained) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Configuration capture and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q <= '0;
      cnt_q <= '0;
      win_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      len_q <= filt_len;
      cnt_q <= filt_count;
      win_q <= win_count;
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  // Element / replay / filter counters and filter base accumulator
  always_ff @(posedge clk) begin
    if (!rst || accept) begin
      e_q    <= '0;
      w_q    <= '0;
      f_q    <= '0;
      base_q <= '0;
    end else if (ren) begin
      if (!elem_end) begin
        e_q <= e_q + ADDR_LEN'(1);
      end else begin
        e_q <= '0;
        if (!win_end) begin
          w_q <= w_q + ADDR_LEN'(1);
        end else begin
          w_q    <= '0;
          f_q    <= f_q + ADDR_LEN'(1);
          base_q <= base_q + {1'b0, len_q};
        end
      end
    end
  end

  // ---- p0 -> p1: read issued, markers travel alongside the returning word
  always_ff @(posedge clk) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= ren;
  end

  always_ff @(posedge clk) begin
    last_elem_p1 <= elem_end;
    last_filt_p1 <= last_filt_p0;
  end

  filt_rd_skid_buf #(
    .DATA_W (SCRATCH_WIDTH)
  ) u_skid (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (vld_p1),
    .in_data       (filt_rdata),
    .in_last_elem  (last_elem_p1),
    .in_last_filt  (last_filt_p1),
    .out_ready     (out_ready),
    .out_valid     (sk_valid),
    .out_data      (sk_data),
    .out_last_elem (sk_last_elem),
    .out_last_filt (sk_last_filt),
    .occupancy     (occ)
  );

  assign filt_scratch_ren = ren;
  assign filt_raddr       = ren ? (base_q[ADDR_LEN-1:0] + e_q) : '0;
  assign out_valid        = sk_valid;
  assign out_data         = sk_valid ? sk_data : '0;
  assign out_last_elem    = sk_valid && sk_last_elem;
  assign out_last_filt    = sk_valid && sk_last_filt;
  assign cfg_err          = err_q;

endmodule

// File: tb/tb_filt_scratch_reader.sv
// Bench for filt_scratch_reader: a scratchpad model answers reads, a
// queue-based model of the replay order predicts every beat and address,
// and a monitor compares the DUT against it each cycle.
module tb_filt_scratch_reader;

  localparam int AL = 4;
  localparam int DEPTH = 16;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AL-1:0] filt_len = '0;
  logic [AL-1:0] filt_count = '0;
  logic [AL-1:0] win_count = '0;
  logic [AL-1:0] filt_raddr;
  logic          filt_scratch_ren;
  logic [SW-1:0] filt_rdata = '0;
  logic [SW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last_elem;
  logic          out_last_filt;
  logic          busy;
  logic          done;
  logic          cfg_err;

  filt_scratch_reader #(
    .ADDR_LEN      (AL),
    .SCRATCH_DEPTH (DEPTH),
    .SCRATCH_WIDTH (SW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .filt_len         (filt_len),
    .filt_count       (filt_count),
    .win_count        (win_count),
    .filt_raddr       (filt_raddr),
    .filt_scratch_ren (filt_scratch_ren),
    .filt_rdata       (filt_rdata),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last_elem    (out_last_elem),
    .out_last_filt    (out_last_filt),
    .busy             (busy),
    .done             (done),
    .cfg_err          (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] d;
    logic          le;
    logic          lf;
  } beat_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [SW-1:0] mem [DEPTH];
  beat_t exp_q[$];
  int    addr_q[$];
  logic  exp_err;

  bit    mon_en = 1'b0;
  bit    prev_stall = 1'b0;
  logic [SW-1:0] prev_data = '0;
  int    hs_count, first_hs, last_hs, done_cyc, ren_count, vld_count, start_cyc;
  int    addr_log[$];
  int    le_log[$];
  int    lf_log[$];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scratchpad contents and its one-cycle read port
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = SW'(16'h1000 + i * 257);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    filt_rdata <= filt_scratch_ren ? mem[filt_raddr] : 16'hDEAD;
  end

  // Reference: replay order straight from the loop description
  task automatic build_model(input int len, input int cnt, input int win);
    int base;
    beat_t b;
    exp_q.delete();
    addr_q.delete();
    exp_err = 1'b0;
    base = 0;
    for (int f = 0; f < cnt; f++) begin
      if (len > 0 && base + len > DEPTH) begin
        exp_err = 1'b1;
        break;
      end
      for (int w = 0; w < win; w++)
        for (int e = 0; e < len; e++) begin
          b.d  = mem[base + e];
          b.le = (e == len - 1);
          b.lf = 1'b0;
          exp_q.push_back(b);
          addr_q.push_back(base + e);
        end
      base += len;
    end
    if (exp_q.size() > 0) exp_q[exp_q.size() - 1].lf = 1'b1;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    beat_t b;
    int a;
    if (mon_en) begin
      if (filt_scratch_ren) begin
        ren_count++;
        addr_log.push_back(int'(filt_raddr));
        if (addr_q.size() == 0) check("unexpected_ren", 1, 0);
        else begin
          a = addr_q.pop_front();
          check("raddr", filt_raddr, a);
        end
      end
      if (prev_stall) check("stall_valid_held", out_valid, 1);
      if (out_valid) begin
        vld_count++;
        if (prev_stall) check("stall_data_held", out_data, prev_data);
        if (out_ready) begin
          hs_count++;
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          if (out_last_elem) le_log.push_back(hs_count);
          if (out_last_filt) lf_log.push_back(hs_count);
          if (exp_q.size() == 0) check("extra_beat", 1, 0);
          else begin
            b = exp_q.pop_front();
            check("out_data", out_data, b.d);
            check("out_last_elem", out_last_elem, b.le);
            check("out_last_filt", out_last_filt, b.lf);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        if (done_cyc < 0) done_cyc = cyc;
        check("busy_at_done", busy, 0);
        check("beats_left_at_done", exp_q.size(), 0);
        check("reads_left_at_done", addr_q.size(), 0);
        check("cfg_err_at_done", cfg_err, exp_err);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_case(input int len, input int cnt, input int win,
                          input bit rand_ready, input int glitch_at, input int budget);
    bit early;
    build_model(len, cnt, win);
    addr_log.delete();
    le_log.delete();
    lf_log.delete();
    hs_count = 0; first_hs = -1; last_hs = -1; done_cyc = -1;
    ren_count = 0; vld_count = 0;
    early = (len != 0) && (cnt != 0) && (win != 0);
    @(posedge clk); #1;
    filt_len   = AL'(len);
    filt_count = AL'(cnt);
    win_count  = AL'(win);
    out_ready  = 1'b1;
    start      = 1'b1;
    start_cyc  = cyc;
    mon_en     = 1'b1;
    for (int i = 1; i <= budget && done_cyc < 0; i++) begin
      @(posedge clk); #1;
      start      = (i == glitch_at);
      filt_len   = 4'd7;
      filt_count = 4'd1;
      win_count  = 4'd5;
      out_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (early && i == 1) begin
        check("cyc1_busy", busy, 1);
        check("cyc1_ren", filt_scratch_ren, 1);
        check("cyc1_raddr", filt_raddr, 0);
      end
      if (early && i == 2) begin
        check("cyc2_valid", out_valid, 1);
        check("cyc2_data", out_data, mem[0]);
      end
    end
    start = 1'b0;
    if (done_cyc < 0) check("done_timeout", 0, 1);
    @(posedge clk); #1;
    check("done_single_pulse", done, 0);
    check("idle_after_done", busy, 0);
    @(negedge clk);
    mon_en = 1'b0;
  endtask

  int basic_addrs[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
  int basic_le[4]     = '{3, 6, 9, 12};

  initial begin
    void'($urandom(32'h5eed));

    // Power-on reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ren", filt_scratch_ren, 0);
    check("rst_valid", out_valid, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b1;

    // Basic run, full throughput
    run_case(3, 2, 2, 1'b0, 0, 200);
    check("basic_ren_count", ren_count, 12);
    check("basic_beats", hs_count, 12);
    for (int i = 0; i < 12; i++)
      check("basic_addr", (i < addr_log.size()) ? addr_log[i] : -1, basic_addrs[i]);
    check("basic_le_count", le_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check("basic_le_pos", (i < le_log.size()) ? le_log[i] : -1, basic_le[i]);
    check("basic_lf_count", lf_log.size(), 1);
    check("basic_lf_pos", (lf_log.size() > 0) ? lf_log[0] : -1, 12);
    check("basic_first_beat_cyc", first_hs - start_cyc, 2);
    check("basic_contiguous", last_hs - first_hs + 1, 12);
    check("basic_done_latency", done_cyc - last_hs, 1);

    // Random backpressure, plus a start pulse while busy
    run_case(3, 2, 2, 1'b1, 4, 400);
    check("bp_beats", hs_count, 12);
    check("bp_done_latency", done_cyc - last_hs, 1);

    // Overflow: third filter does not fit in 16 words
    run_case(6, 3, 1, 1'b0, 0, 200);
    check("ovf_beats", hs_count, 12);
    check("ovf_last_addr", (addr_log.size() > 0) ? addr_log[addr_log.size() - 1] : -1, 11);
    check("ovf_lf_pos", (lf_log.size() > 0) ? lf_log[0] : -1, 12);
    check("ovf_cfg_err", cfg_err, 1);

    // Single-element filters, every beat closes an element run
    run_case(1, 3, 2, 1'b1, 0, 400);
    check("len1_beats", hs_count, 6);
    check("len1_le_count", le_log.size(), 6);
    check("len1_cfg_err_cleared", cfg_err, 0);

    // Zero replay count
    run_case(3, 2, 0, 1'b0, 0, 50);
    check("zero_done_cyc", done_cyc - start_cyc, 1);
    check("zero_ren", ren_count, 0);
    check("zero_valid", vld_count, 0);

    // Reset mid-stream with the buffer full
    @(posedge clk); #1;
    filt_len = 4'd3; filt_count = 4'd2; win_count = 4'd2;
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_busy", busy, 1);
    check("stall_valid", out_valid, 1);
    check("stall_no_ren", filt_scratch_ren, 0);
    check("stall_head", out_data, mem[0]);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_ren", filt_scratch_ren, 0);
    check("midrst_raddr", filt_raddr, 0);
    check("midrst_markers", {out_last_elem, out_last_filt}, 0);
    check("midrst_done", done, 0);
    rst = 1'b1;

    // Restart after reset
    run_case(3, 2, 2, 1'b0, 0, 200);
    check("restart_beats", hs_count, 12);
    check("restart_first_addr", (addr_log.size() > 0) ? addr_log[0] : -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
